logic_op_issue: RTL and testbench

//   Issue and retire stage around logic_module.
//   - Queues (a, b, select) commands arriving on a valid/ready input.
//   - Drives the oldest queued command onto logic_module's a/b/select ports.
//   - Registers logic_module's result into an output slot with a valid/ready handshake.
//   - Decouples the upstream producer from the downstream consumer.

---
 rtl/logic_pkg.sv | 18 +
 rtl/logic_cmd_fifo.sv | 58 +++++
 rtl/logic_module.sv | 24 ++
 rtl/logic_op_issue.sv | 128 ++++++++++++
 tb/tb_logic_op_issue.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/logic_pkg.sv
// Shared opcodes, command packing helpers and slot state for the logic issue stage.
package logic_pkg;

  localparam logic [1:0] OP_AND   = 2'b00;
  localparam logic [1:0] OP_OR    = 2'b01;
  localparam logic [1:0] OP_XOR   = 2'b10;
  localparam logic [1:0] OP_NOT_A = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } slot_state_e;

  function automatic int cmd_w(input int n);
    return 2 * n + 2;
  endfunction

endpackage

// File: rtl/logic_cmd_fifo.sv
// DEPTH x W synchronous command FIFO with count, full and empty flags.
module logic_cmd_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/logic_module.sv
// Combinational logic unit: AND, OR, XOR or NOT a, picked by select.
module logic_module
  import logic_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   select,
  output logic [N-1:0] result
);

  always_comb begin
    result = '0;
    unique case (select)
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOT_A: result = ~a;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_issue.sv
// Issue/retire stage around logic_module: command FIFO, issue mux, result slot.
// Optional retired-op counter enabled by LOGIC_ISSUE_STATS_EN.
module logic_op_issue
  import logic_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [1:0]       in_select,
  output logic [N-1:0]     lgc_a,
  output logic [N-1:0]     lgc_b,
  output logic [1:0]       lgc_select,
  input  logic [N-1:0]     lgc_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
`ifdef LOGIC_ISSUE_STATS_EN
  output logic [CNT_W-1:0] op_count,
`endif
  output logic [1:0]       out_select
);

  localparam int CMD_W = cmd_w(N);

  logic [CMD_W-1:0] head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             hs;
  logic [N-1:0]     head_a;
  logic [N-1:0]     head_b;
  logic [1:0]       head_sel;

  slot_state_e      state_q;
  logic             out_valid_q;
  logic [N-1:0]     out_result_q;
  logic [1:0]       out_select_q;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!out_valid_q || out_ready);
  assign hs       = out_valid_q && out_ready;

  assign {head_sel, head_a, head_b} = head;

  logic_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({in_select, in_a, in_b}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign lgc_a      = empty ? '0 : head_a;
  assign lgc_b      = empty ? '0 : head_b;
  assign lgc_select = empty ? '0 : head_sel;

  // A pop while HOLD refills the slot in the same cycle it retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_select_q <= '0;
    end else begin
      if (pop) begin
        out_result_q <= lgc_result;
        out_select_q <= head_sel;
      end
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q     <= S_HOLD;
            out_valid_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (!pop && out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_select = out_select_q;

`ifdef LOGIC_ISSUE_STATS_EN
  logic [CNT_W-1:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (hs && (op_count_q != '1)) op_count_d = op_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_count_q <= '0;
    else     op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_logic_op_issue.sv
// Directed self-checking bench for logic_op_issue wired to logic_module.
module tb_logic_op_issue;
  import logic_pkg::*;

  localparam int N = 4;
`ifdef LOGIC_ISSUE_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_a = '0;
  logic [N-1:0]     in_b = '0;
  logic [1:0]       in_select = '0;
  logic [N-1:0]     lgc_a;
  logic [N-1:0]     lgc_b;
  logic [1:0]       lgc_select;
  logic [N-1:0]     lgc_result;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-1:0]     out_result;
  logic [1:0]       out_select;
`ifdef LOGIC_ISSUE_STATS_EN
  logic [CNT_W-1:0] op_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  logic_op_issue #(
    .N     (N),
    .DEPTH (2),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_select  (in_select),
    .lgc_a      (lgc_a),
    .lgc_b      (lgc_b),
    .lgc_select (lgc_select),
    .lgc_result (lgc_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
`ifdef LOGIC_ISSUE_STATS_EN
    .op_count   (op_count),
`endif
    .out_select (out_select)
  );

  logic_module #(.N(N)) u_lgc (
    .a      (lgc_a),
    .b      (lgc_b),
    .select (lgc_select),
    .result (lgc_result)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] s);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_select = s;
    tick();
    in_valid  = 1'b0;
  endtask

  logic [3:0] exp3 [4];
  logic [3:0] c_a  [3];
  logic [3:0] c_b  [3];
  logic [1:0] c_s  [3];
  logic [3:0] c_r  [3];

  initial begin
    exp3[0] = 4'b0100; exp3[1] = 4'b0111;
    exp3[2] = 4'b0011; exp3[3] = 4'b1010;
    c_a[0] = 4'hC; c_b[0] = 4'hA; c_s[0] = OP_OR;  c_r[0] = 4'hE;
    c_a[1] = 4'h3; c_b[1] = 4'h5; c_s[1] = OP_XOR; c_r[1] = 4'h6;
    c_a[2] = 4'hF; c_b[2] = 4'h3; c_s[2] = OP_AND; c_r[2] = 4'h3;

    // 1: reset asserted mid-cycle
    #7 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_lgc_a",     32'(lgc_a),     32'd0);
    chk("rst_lgc_b",     32'(lgc_b),     32'd0);
    chk("rst_lgc_sel",   32'(lgc_select), 32'd0);
    chk("rst_out_res",   32'(out_result), 32'd0);
`ifdef LOGIC_ISSUE_STATS_EN
    chk("rst_op_count",  32'(op_count),  32'd0);
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 2: single op latency
    push(4'd5, 4'd6, OP_AND);
    chk("lat_k_valid", 32'(out_valid), 32'd0);
    chk("lat_k_lgc_a", 32'(lgc_a), 32'd5);
    chk("lat_k_lgc_b", 32'(lgc_b), 32'd6);
    tick();
    chk("lat_k1_valid", 32'(out_valid), 32'd1);
    chk("lat_k1_res",   32'(out_result), 32'b0100);
    chk("lat_k1_sel",   32'(out_select), 32'(OP_AND));
    chk("lat_k1_lgc_a", 32'(lgc_a), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("lat_drain", 32'(out_valid), 32'd0);

    // 3: back-to-back, one result per cycle
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        in_valid  = 1'b1;
        in_a      = 4'd5;
        in_b      = 4'd6;
        in_select = 2'(i);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 4) begin
        chk($sformatf("b2b_valid%0d", i - 1), 32'(out_valid), 32'd1);
        chk($sformatf("b2b_res%0d", i - 1), 32'(out_result), 32'(exp3[i-1]));
        chk($sformatf("b2b_sel%0d", i - 1), 32'(out_select), 32'(i - 1));
      end
      if (i < 4) chk($sformatf("b2b_rdy%0d", i), 32'(in_ready), 32'd1);
    end
    chk("b2b_idle", 32'(out_valid), 32'd0);

    // 4: backpressure, FIFO fills, then drains in order
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(c_a[i], c_b[i], c_s[i]);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_res0", 32'(out_result), 32'(c_r[0]));
    tick();
    tick();
    chk("bp_hold_res", 32'(out_result), 32'(c_r[0]));
    chk("bp_hold_sel", 32'(out_select), 32'(c_s[0]));
    chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      chk($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_res%0d", i), 32'(out_result), 32'(c_r[i]));
      chk($sformatf("bp_sel%0d", i), 32'(out_select), 32'(c_s[i]));
    end
    tick();
    chk("bp_done", 32'(out_valid), 32'd0);
    chk("bp_rdy", 32'(in_ready), 32'd1);

    // 5: reset with queued and in-flight commands
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(c_a[i], c_b[i], c_s[i]);
    chk("r5_pre_valid", 32'(out_valid), 32'd1);
    chk("r5_pre_rdy", 32'(in_ready), 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("r5_valid", 32'(out_valid), 32'd0);
    chk("r5_rdy", 32'(in_ready), 32'd1);
    chk("r5_lgc_a", 32'(lgc_a), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("r5_quiet%0d", i), 32'(out_valid), 32'd0);
    end
    push(4'h9, 4'h0, OP_NOT_A);
    tick();
    chk("r5_new_valid", 32'(out_valid), 32'd1);
    chk("r5_new_res", 32'(out_result), 32'h6);
    chk("r5_new_sel", 32'(out_select), 32'(OP_NOT_A));
    tick();

`ifdef LOGIC_ISSUE_STATS_EN
    // 6: saturating retired-op counter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("cnt_init", 32'(op_count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0;
      push(4'(i), 4'hF, OP_AND);
      tick();
      out_ready = 1'b1;
      tick();
      chk($sformatf("cnt%0d", i), 32'(op_count), (i < 3) ? 32'(i + 1) : 32'd3);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
